// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Fetch stage of the multi-cycle RV32I core. Owns the architectural PC, issues
// one instruction-memory read per instruction, captures the returned word into
// the instruction register and hands it to decode through a valid/ready
// handshake. On acceptance the next PC supplied by program_counter is committed;
// a misaligned next PC parks the stage in a sticky FAULT state until reset.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   pc_next      next PC from program_counter (sampled only on acceptance)
//   imem_addr    instruction memory byte address (= current PC)
//   imem_rd_en   one-cycle read strobe (combinational, FETCH state only)
//   imem_rdata   instruction memory read data, valid READ_LATENCY cycles later
//   instr        instruction register
//   instr_pc     PC of the word held in instr (to program_counter pc_in)
//   instr_valid  instr/instr_pc hold a fetched instruction
//   instr_ready  consumer accepts instr; pc_next is final this cycle
//   misaligned   sticky fault: pc_next[1:0] != 0 on an acceptance
//   instr_count  number of accepted instructions, wraps modulo 2^32
// -----------------------------------------------------------------------------
module instr_fetch #(
   parameter logic [31:0] RESET_PC     = 32'h0000_1000,
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_next,
   output logic [31:0] imem_addr,
   output logic        imem_rd_en,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic        misaligned,
   output logic [31:0] instr_count
);

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_WAIT  = 2'd1,
      ST_HOLD  = 2'd2,
      ST_FAULT = 2'd3
   } state_t;

   // Latency counter start value; 3 bits cover the legal range 1..7.
   localparam logic [2:0] LAT_INIT = 3'(READ_LATENCY);

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [2:0]  lat_q, lat_d;
   logic [31:0] instr_q, instr_d;
   logic        valid_q, valid_d;
   logic        mis_q, mis_d;
   logic [31:0] instr_count_q, instr_count_d;
   logic        rd_en_s;

   // Next-state and datapath update for the fetch FSM.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      lat_d         = lat_q;
      instr_d       = instr_q;
      valid_d       = valid_q;
      mis_d         = mis_q;
      instr_count_d = instr_count_q;
      rd_en_s       = 1'b0;

      case (state_q)
         ST_FETCH: begin
            // Suppressed while rst is high so no read leaks out of a reset cycle.
            rd_en_s = ~rst;
            lat_d   = LAT_INIT;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            lat_d = lat_q - 3'd1;
            // Counter at 1 marks the cycle the memory presents the word.
            if (lat_q == 3'd1) begin
               instr_d = imem_rdata;
               valid_d = 1'b1;
               state_d = ST_HOLD;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_HOLD: begin
            if (valid_q && instr_ready) begin
               instr_count_d = instr_count_q + 32'd1;
               valid_d       = 1'b0;
               // A misaligned target is never fetched: keep the old PC for debug.
               if (pc_next[1:0] == 2'b00) begin
                  pc_d    = pc_next;
                  state_d = ST_FETCH;
               end else begin
                  mis_d   = 1'b1;
                  state_d = ST_FAULT;
               end
            end else begin
               state_d = ST_HOLD;
            end
         end
         ST_FAULT: begin
            valid_d = 1'b0;
            state_d = ST_FAULT;
         end
         default: begin
            state_d = ST_FETCH;
            valid_d = 1'b0;
         end
      endcase
   end

   // State register with synchronous reset; reset also discards any read in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_FETCH;
         pc_q          <= RESET_PC;
         lat_q         <= 3'd0;
         instr_q       <= 32'd0;
         valid_q       <= 1'b0;
         mis_q         <= 1'b0;
         instr_count_q <= 32'd0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         lat_q         <= lat_d;
         instr_q       <= instr_d;
         valid_q       <= valid_d;
         mis_q         <= mis_d;
         instr_count_q <= instr_count_d;
      end
   end

   assign imem_addr   = pc_q;
   assign instr_pc    = pc_q;
   assign imem_rd_en  = rd_en_s;
   assign instr       = instr_q;
   assign instr_valid = valid_q;
   assign misaligned  = mis_q;
   assign instr_count = instr_count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Self-checking bench for instr_fetch. Two instances: dut (READ_LATENCY = 1)
// carries the main sequence, dut3 (READ_LATENCY = 3) covers reset during a
// read. Each has a small latency-accurate instruction memory whose returned
// word depends on address and request number, so a stale or extra read
// shows up as a wrong instruction.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

   localparam logic [31:0] RESET_PC = 32'h0000_1000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // dut signals
   logic        rst, instr_ready, imem_rd_en, instr_valid, misaligned;
   logic [31:0] pc_next, imem_addr, imem_rdata, instr, instr_pc, instr_count;
   // dut3 signals
   logic        rst3, instr_ready3, imem_rd_en3, instr_valid3, misaligned3;
   logic [31:0] pc_next3, imem_addr3, imem_rdata3, instr3, instr_pc3, instr_count3;

   int vectors     = 0;
   int miscompares = 0;

   logic [31:0] salt;
   int          mseq1 = 0;
   int          mseq3 = 0;
   logic [31:0] d0, d1, d2;

   // model state for dut
   logic [31:0] m_pc, m_count, m_word;
   int          m_seq1;

   instr_fetch #(.RESET_PC(RESET_PC), .READ_LATENCY(1)) dut (
      .clk(clk), .rst(rst), .pc_next(pc_next), .imem_addr(imem_addr),
      .imem_rd_en(imem_rd_en), .imem_rdata(imem_rdata), .instr(instr),
      .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .misaligned(misaligned), .instr_count(instr_count)
   );

   instr_fetch #(.RESET_PC(RESET_PC), .READ_LATENCY(3)) dut3 (
      .clk(clk), .rst(rst3), .pc_next(pc_next3), .imem_addr(imem_addr3),
      .imem_rd_en(imem_rd_en3), .imem_rdata(imem_rdata3), .instr(instr3),
      .instr_pc(instr_pc3), .instr_valid(instr_valid3), .instr_ready(instr_ready3),
      .misaligned(misaligned3), .instr_count(instr_count3)
   );

   // Memory content: fixed reset-vector word for the very first read,
   // otherwise a scramble of address and request number.
   function automatic logic [31:0] mem_word(input logic [31:0] addr, input int seq);
      if (addr == 32'h0000_1000 && seq == 0) return 32'h0050_0093;
      return (addr * 32'h9E37_79B1) ^ (32'(seq) * 32'h0101_0101) ^ salt;
   endfunction

   // Latency-1 memory: word appears the cycle after the strobe, garbage otherwise.
   always @(posedge clk) begin
      if (imem_rd_en) begin
         imem_rdata <= mem_word(imem_addr, mseq1);
         mseq1      <= mseq1 + 1;
      end else begin
         imem_rdata <= $urandom;
      end
   end

   // Latency-3 memory: three-deep delay line.
   always @(posedge clk) begin
      if (imem_rd_en3) begin
         d0    <= mem_word(imem_addr3, mseq3);
         mseq3 <= mseq3 + 1;
      end else begin
         d0    <= $urandom;
      end
      d1 <= d0;
      d2 <= d1;
   end
   assign imem_rdata3 = d2;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called in the strobe cycle; returns in the first cycle instr_valid is high.
   task automatic fetch1();
      logic [31:0] r;
      chk("rd_en", 32'(imem_rd_en), 32'd1);
      chk("imem_addr", imem_addr, m_pc);
      m_word = mem_word(m_pc, m_seq1);
      m_seq1++;
      for (int k = 1; k <= 2; k++) begin
         // ready and pc_next outside HOLD must be ignored
         instr_ready = 1'($urandom_range(0, 1));
         r = $urandom;
         pc_next = r;
         step();
         instr_ready = 1'b0;
         if (k == 1) begin
            chk("wait_valid", 32'(instr_valid), 32'd0);
            chk("wait_rd_en", 32'(imem_rd_en), 32'd0);
         end
      end
      chk("instr_valid", 32'(instr_valid), 32'd1);
      chk("instr", instr, m_word);
      chk("instr_pc", instr_pc, m_pc);
      chk("instr_count", instr_count, m_count);
   endtask

   task automatic hold1(input int n);
      for (int i = 0; i < n; i++) begin
         pc_next = $urandom;
         step();
         chk("hold_valid", 32'(instr_valid), 32'd1);
         chk("hold_instr", instr, m_word);
         chk("hold_pc", instr_pc, m_pc);
         chk("hold_rd_en", 32'(imem_rd_en), 32'd0);
      end
   endtask

   task automatic accept1(input logic [31:0] np);
      instr_ready = 1'b1;
      pc_next     = np;
      step();
      instr_ready = 1'b0;
      m_count     = m_count + 32'd1;
      if (np[1:0] == 2'b00) m_pc = np;
      chk("acc_count", instr_count, m_count);
      chk("acc_valid", 32'(instr_valid), 32'd0);
      chk("acc_misaligned", 32'(misaligned), 32'(np[1:0] != 2'b00));
      chk("acc_addr", imem_addr, m_pc);
   endtask

   initial begin
      logic [31:0] r, np;
      salt         = $urandom;
      rst          = 1'b1;
      rst3         = 1'b1;
      instr_ready  = 1'b0;
      instr_ready3 = 1'b0;
      pc_next      = 32'd0;
      pc_next3     = 32'd0;
      m_pc         = RESET_PC;
      m_count      = 32'd0;
      m_seq1       = 0;

      // reset state
      step();
      step();
      chk("rst_instr", instr, 32'd0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_misaligned", 32'(misaligned), 32'd0);
      chk("rst_count", instr_count, 32'd0);
      chk("rst_addr", imem_addr, RESET_PC);
      chk("rst_instr_pc", instr_pc, RESET_PC);
      chk("rst_rd_en", 32'(imem_rd_en), 32'd0);

      // first fetch right after reset release
      rst = 1'b0;
      #1;
      fetch1();
      chk("first_instr", instr, 32'h0050_0093);

      // backpressure, then sequential and branch targets
      hold1(5);
      accept1(32'h0000_1004);
      fetch1();
      accept1(32'h0000_2010);
      fetch1();

      // random backpressure and aligned targets, sometimes refetching the same PC
      for (int i = 0; i < 10; i++) begin
         hold1($urandom_range(0, 3));
         r  = $urandom;
         np = ($urandom_range(0, 3) == 0) ? m_pc : (r & 32'hFFFF_FFFC);
         accept1(np);
         fetch1();
      end

      // counter wrap
      force dut.instr_count_q = 32'hFFFF_FFFF;
      #1;
      release dut.instr_count_q;
      m_count = 32'hFFFF_FFFF;
      hold1(1);
      chk("wrap_preset", instr_count, 32'hFFFF_FFFF);
      accept1(m_pc + 32'd4);
      chk("wrap_zero", instr_count, 32'd0);
      fetch1();

      // misaligned target: sticky fault, no reads, ready ignored
      hold1(2);
      accept1(32'h0000_2002);
      for (int i = 0; i < 20; i++) begin
         instr_ready = 1'($urandom_range(0, 1));
         pc_next     = $urandom & 32'hFFFF_FFFC;
         step();
         chk("fault_rd_en", 32'(imem_rd_en), 32'd0);
         chk("fault_valid", 32'(instr_valid), 32'd0);
         chk("fault_sticky", 32'(misaligned), 32'd1);
         chk("fault_count", instr_count, m_count);
         chk("fault_pc", imem_addr, m_pc);
      end
      instr_ready = 1'b0;

      // reset clears the fault and fetching resumes at the reset vector
      rst = 1'b1;
      step();
      chk("rst2_misaligned", 32'(misaligned), 32'd0);
      chk("rst2_count", instr_count, 32'd0);
      chk("rst2_addr", imem_addr, RESET_PC);
      chk("rst2_rd_en", 32'(imem_rd_en), 32'd0);
      m_pc    = RESET_PC;
      m_count = 32'd0;
      rst     = 1'b0;
      #1;
      fetch1();

      // READ_LATENCY = 3: reset one cycle after the strobe
      rst3 = 1'b0;
      #1;
      chk("l3_rd_en", 32'(imem_rd_en3), 32'd1);
      chk("l3_addr", imem_addr3, RESET_PC);
      step();
      chk("l3_wait_valid", 32'(instr_valid3), 32'd0);
      rst3 = 1'b1;
      step();
      chk("l3_rst_valid", 32'(instr_valid3), 32'd0);
      chk("l3_rst_rd_en", 32'(imem_rd_en3), 32'd0);
      chk("l3_rst_instr", instr3, 32'd0);
      rst3 = 1'b0;
      #1;
      chk("l3_refetch_rd_en", 32'(imem_rd_en3), 32'd1);
      chk("l3_refetch_addr", imem_addr3, RESET_PC);
      for (int k = 1; k <= 4; k++) begin
         step();
         if (k < 4) begin
            chk("l3_pending_valid", 32'(instr_valid3), 32'd0);
            chk("l3_pending_rd_en", 32'(imem_rd_en3), 32'd0);
         end
      end
      chk("l3_valid", 32'(instr_valid3), 32'd1);
      chk("l3_instr", instr3, mem_word(RESET_PC, 1));
      chk("l3_instr_pc", instr_pc3, RESET_PC);
      chk("l3_count", instr_count3, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
